// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a CPU write port and a UART transmitter pop port, with registered status flags.
// Optional sticky overflow detection is enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AFULL_LVL  = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr,
  input  logic [7:0]            wdat,
  output logic                  full,
  output logic                  afull,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  rd,
  output logic                  rdempty,
  output logic [7:0]            idat,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int PW = DEPTH_LOG2;
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_LVL = LW'(1 << DEPTH_LOG2);
  localparam logic [LW-1:0] AFULL_THR = LW'(AFULL_LVL);

  logic [7:0]    mem [0:(1<<PW)-1];
  logic [PW-1:0] wptr_reg;
  logic [PW-1:0] rptr_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic          full_reg;
  logic          afull_reg;
  logic          rdempty_reg;
  logic [7:0]    idat_reg;
  logic          rd_acc;
  logic          wr_acc;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a write alongside it.
  assign rd_acc = rd & ~rdempty_reg;
  assign wr_acc = wr & (~full_reg | rd_acc);

  always_comb begin
    level_next = level_reg;
    if (wr_acc && !rd_acc)
      level_next = level_reg + LW'(1);
    else if (!wr_acc && rd_acc)
      level_next = level_reg - LW'(1);
  end

  always_ff @(posedge CLK) begin
    if (wr_acc)
      mem[wptr_reg] <= wdat;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      level_reg   <= '0;
      full_reg    <= 1'b0;
      afull_reg   <= 1'b0;
      rdempty_reg <= 1'b1;
      idat_reg    <= 8'h00;
    end else begin
      if (wr_acc)
        wptr_reg <= wptr_reg + PW'(1);
      if (rd_acc) begin
        idat_reg <= mem[rptr_reg];
        rptr_reg <= rptr_reg + PW'(1);
      end
      // Flags derive from the next level so they stay in step with level every cycle.
      level_reg   <= level_next;
      full_reg    <= (level_next == DEPTH_LVL);
      afull_reg   <= (level_next >= AFULL_THR);
      rdempty_reg <= (level_next == '0);
    end
  end

  assign level   = level_reg;
  assign full    = full_reg;
  assign afull   = afull_reg;
  assign rdempty = rdempty_reg;
  assign idat    = idat_reg;

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      ovf_reg <= 1'b0;
    else if (wr & ~wr_acc)
      ovf_reg <= 1'b1;
    else if (ovf_clr)
      ovf_reg <= 1'b0;
  end

  assign ovf = ovf_reg;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int AFULL_LVL  = 12;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef UART_TX_FIFO_OVF_EN
  localparam int OVF_EXP = 1;
`else
  localparam int OVF_EXP = 0;
`endif

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              wr = 1'b0;
  logic [7:0]        wdat = 8'h00;
  logic              rd = 1'b0;
  logic              ovf_clr = 1'b0;
  logic              full;
  logic              afull;
  logic [DEPTH_LOG2:0] level;
  logic              rdempty;
  logic [7:0]        idat;
  logic              ovf;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .AFULL_LVL(AFULL_LVL)) dut (
    .CLK(CLK), .RST(RST), .wr(wr), .wdat(wdat), .full(full), .afull(afull),
    .level(level), .rd(rd), .rdempty(rdempty), .idat(idat), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored bytes, the last popped byte and the sticky flag.
  logic [7:0] q[$];
  logic [7:0] idat_m = 8'h00;
  int         ovf_m  = 0;

  initial forever begin
    @(posedge CLK or negedge RST);
    if (!RST) begin
      q.delete();
      idat_m = 8'h00;
      ovf_m  = 0;
    end else begin
      int  sz;
      bit  popped;
      bit  dropped;
      sz      = q.size();
      popped  = 1'b0;
      dropped = 1'b0;
      if (rd && sz > 0) begin
        idat_m = q.pop_front();
        popped = 1'b1;
      end
      if (wr) begin
        if (sz < DEPTH || popped) q.push_back(wdat);
        else dropped = 1'b1;
      end
      if (OVF_EXP != 0) begin
        if (dropped) ovf_m = 1;
        else if (ovf_clr) ovf_m = 0;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    chk("level",   int'(level),   q.size());
    chk("full",    int'(full),    int'(q.size() == DEPTH));
    chk("afull",   int'(afull),   int'(q.size() >= AFULL_LVL));
    chk("rdempty", int'(rdempty), int'(q.size() == 0));
    chk("idat",    int'(idat),    int'(idat_m));
    chk("ovf",     int'(ovf),     ovf_m);
  end

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr = w; wdat = d; rd = r; ovf_clr = c;
    @(posedge CLK);
    #1;
    wr = 1'b0; rd = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"},   int'(level),   0);
    chk({tag, "_rdempty"}, int'(rdempty), 1);
    chk({tag, "_full"},    int'(full),    0);
    chk({tag, "_afull"},   int'(afull),   0);
    chk({tag, "_idat"},    int'(idat),    0);
    chk({tag, "_ovf"},     int'(ovf),     0);
  endtask

  initial begin
    int pw;
    int pr;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_state("reset");
    #2 RST = 1'b1;
    @(posedge CLK);
    #1;

    // Three writes then three pops.
    step(1'b1, 8'h41, 1'b0, 1'b0);
    chk("first_wr_rdempty", int'(rdempty), 0);
    chk("first_wr_level",   int'(level),   1);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    chk("three_level", int'(level), 3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop1", int'(idat), 'h41);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop2", int'(idat), 'h42);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop3", int'(idat), 'h43);
    chk("pop3_rdempty", int'(rdempty), 1);

    // Fill to full, overflow attempt, clear, drain.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == AFULL_LVL - 2) chk("afull_below", int'(afull), 0);
      if (i == AFULL_LVL - 1) chk("afull_at",    int'(afull), 1);
      if (i == DEPTH - 2)     chk("full_below",  int'(full),  0);
      if (i == DEPTH - 1)     chk("full_at",     int'(full),  1);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("drop_level", int'(level), 16);
    chk("drop_ovf",   int'(ovf),   OVF_EXP);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_sticky", int'(ovf), OVF_EXP);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", int'(ovf), 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_full", int'(idat), i);
    end
    chk("drain_rdempty", int'(rdempty), 1);

    // Pointer wrap: 12 writes, one pop, 4 more writes, then drain in order.
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_first", int'(idat), 'h80);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    chk("wrap_level", int'(level), 15);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_order", int'(idat), (i < 11) ? ('h81 + i) : ('hC0 + i - 11));
    end

    // Write and pop together while full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("fullrw_level", int'(level), 16);
    chk("fullrw_idat",  int'(idat),  'h10);
    chk("fullrw_full",  int'(full),  1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fullrw_drain", int'(idat), (i < 15) ? ('h11 + i) : 'hAA);
    end

    // Write and pop together while empty: pop is ignored.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("emptyrw_idat",  int'(idat),  'hAA);
    chk("emptyrw_level", int'(level), 1);
    step(1'b1, 8'h56, 1'b0, 1'b0);
    step(1'b1, 8'h57, 1'b0, 1'b0);
    chk("pre_rst_level", int'(level), 3);
    #3 RST = 1'b0;
    #1;
    chk_reset_state("async_rst");
    #2 RST = 1'b1;
    @(posedge CLK);
    #1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_first", int'(idat), 'h77);
    chk("post_rst_empty", int'(rdempty), 1);

    // Randomised traffic with varying write/pop densities and occasional resets.
    pw = 50;
    pr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      wr      = ($urandom_range(0, 99) < pw);
      rd      = ($urandom_range(0, 99) < pr);
      wdat    = 8'($urandom);
      ovf_clr = ($urandom_range(0, 19) == 0);
      @(posedge CLK);
      #1;
      if (c % 700 == 699) begin
        wr = 1'b0; rd = 1'b0; ovf_clr = 1'b0;
        #2 RST = 1'b0;
        #1 chk("rand_rst_level", int'(level), 0);
        #1 RST = 1'b1;
      end
    end
    wr = 1'b0; rd = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-002 Parameter AFULL_LVL, default 12: almost-full threshold, in entries.
REQ-003 Port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port RST, input, 1: asynchronous, active-low reset.
REQ-005 Port wr, input, 1: write strobe from the bus/CPU side; one byte per high cycle.
REQ-006 Port wdat, input, 8: write data, sampled when wr=1.
REQ-007 Port full, output, 1: high when level = DEPTH.
REQ-008 Port afull, output, 1: high when level >= AFULL_LVL.
REQ-009 Port level, output, DEPTH_LOG2+1: current number of stored entries.
REQ-010 Port rd, input, 1: pop strobe from the UART transmitter.
REQ-011 Port rdempty, output, 1: high when level = 0.
REQ-012 Port idat, output, 8: last popped byte, held stable until the next accepted pop.
REQ-013 Port ovf, output, 1: sticky overflow flag (see Configuration).
REQ-014 Port ovf_clr, input, 1: clears ovf.

Function
REQ-015 Storage: 2**DEPTH_LOG2 x 8 array; write pointer and read pointer are DEPTH_LOG2 bits wide and wrap modulo the depth.
REQ-016 Accepted write = wr & (~full | rd_acc): store wdat at wptr, then increment wptr.
REQ-017 Accepted pop rd_acc = rd & ~rdempty: load idat <= mem[rptr] on the same edge, then increment rptr.
REQ-018 Pop latency: idat carries the popped byte from the first edge after rd; idat is unchanged in all other cycles.
REQ-019 rd while rdempty=1 is ignored: no pointer, level, or idat change.
REQ-020 wr while full with no accepted pop is dropped: no pointer or level change, and memory is not modified.
REQ-021 Simultaneous accepted write and pop: both occur and level is unchanged; this holds when full as well.
REQ-022 When empty, wr & rd: the write is accepted, the pop is ignored, and level becomes 1.
REQ-023 Level update: +1 on write only, -1 on pop only, 0 on both or neither; level never exceeds DEPTH and never goes below 0.
REQ-024 full, afull, and rdempty are registered flags that are consistent with level in every cycle; there are no combinational paths from wr or rd to any output.
REQ-025 A byte written in cycle N is poppable no earlier than cycle N+1, because rdempty falls at edge N+1.
REQ-026 Bytes are popped in strict write order, including across pointer wrap-around.

Reset
REQ-027 While RST=0, all of the following hold immediately and asynchronously: wptr=0, rptr=0, level=0, rdempty=1, full=0, afull=0, idat=8'h00, ovf=0.
REQ-028 Memory contents are not reset; stale data is never visible, because idat only loads on an accepted pop.
REQ-029 Reset asserted mid-operation discards all stored bytes; the first accepted write after release is the first byte popped.
REQ-030 Deassertion of RST is synchronised externally; the block requires no special handling of the first cycle after release.

Configuration
REQ-031 Macro UART_TX_FIFO_OVF_EN enables overflow detection.
REQ-032 With UART_TX_FIFO_OVF_EN defined: ovf is set on the edge following any dropped write (REQ-020), and is cleared by ovf_clr=1; if set and clear occur in the same cycle, set wins.
REQ-033 Without UART_TX_FIFO_OVF_EN: ovf is tied to 0, ovf_clr is ignored, and the port list is identical.

Verification
REQ-034 Reset, then write 8'h41, 8'h42, 8'h43 on consecutive cycles -> level=3 and rdempty=0 one edge after the first write; three pops return 41, 42, 43 on idat, and rdempty=1 after the third pop.
REQ-035 Write 16 bytes 00..0F (DEPTH_LOG2=4) -> afull rises when level reaches 12 and full rises at 16; a 17th write of 8'hFF is dropped, and 16 pops return 00..0F; with the macro defined, ovf=1 until ovf_clr is asserted.
REQ-036 Pop once, then write 4 more bytes so pointers wrap, then drain -> the output order is exactly the write order, with no duplicates or losses.
REQ-037 When full, assert wr=1 (8'hAA) and rd=1 in the same cycle -> level stays 16, the oldest byte appears on idat, and 8'hAA is popped last.
REQ-038 When empty, assert wr and rd together with 8'h55 -> idat is unchanged and level=1; hold 3 bytes, pulse RST low mid-stream -> all outputs match REQ-027 without waiting for a clock edge.
